// File: rtl/mux_seq_ctrl.sv
// Lane sequencer for a downstream 4:1 mux: issues LEN beats on each enabled lane, then pulses done.
// Optional build macro MUX_SEQ_LANE_MASK_EN adds a lane_mask input that is captured on start.
module mux_seq_ctrl #(
  parameter int LEN = 8,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          start,
`ifdef MUX_SEQ_LANE_MASK_EN
  input  logic [3:0]    lane_mask,
`endif
  output logic [1:0]    sel,
  output logic          sel_valid,
  output logic          lane_last,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] beat,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BEAT = CW'(LEN - 1);

  logic [1:0] state;
  logic [3:0] mask_q;
  logic [3:0] start_mask;
  logic [1:0] first_lane;
  logic       first_ok;
  logic [1:0] next_lane;
  logic       next_ok;

`ifdef MUX_SEQ_LANE_MASK_EN
  assign start_mask = lane_mask;
`else
  assign start_mask = 4'hF;
  assign mask_q     = 4'hF;
`endif

  // Lowest enabled lane at start, and lowest enabled lane above the current one.
  always_comb begin
    first_lane = 2'd0;
    first_ok   = 1'b0;
    next_lane  = 2'd0;
    next_ok    = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (start_mask[i]) begin
        first_lane = 2'(i);
        first_ok   = 1'b1;
      end
      if (mask_q[i] && (2'(i) > sel)) begin
        next_lane = 2'(i);
        next_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      beat      <= '0;
      sel_valid <= 1'b0;
      done      <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (start) begin
            if (first_ok) begin
              state     <= RUN;
              sel       <= first_lane;
              beat      <= '0;
              sel_valid <= 1'b1;
            end else begin
              // Empty mask: nothing to issue, report completion right away.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat != LAST_BEAT) begin
            beat <= beat + 1'b1;
          end else begin
            beat <= '0;
            if (next_ok) begin
              sel <= next_lane;
            end else begin
              state     <= DONE;
              sel_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          sel_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_SEQ_LANE_MASK_EN
  // Mask is frozen for the whole sequence so mid-run changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 4'hF;
    end else if (ce && (state == IDLE) && start) begin
      mask_q <= lane_mask;
    end
  end
`endif

  assign lane_last = (state == RUN) && (beat == LAST_BEAT);
  assign busy      = (state == RUN) || (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// Bench for mux_seq_ctrl: LEN=4 and LEN=1 instances share random ce/start/rst stimulus and are
// checked every cycle against a queue-based schedule model (define MUX_SEQ_LANE_MASK_EN to test the mask).
module tb_mux_seq_ctrl;

  localparam int CW = 8;

  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_BEAT = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef logic [11:0] ent_t;  // {kind[1:0], lane[1:0], beat[7:0]}

  logic          clk;
  logic          rst;
  logic          ce;
  logic          start;
  logic [3:0]    lane_mask;

  logic [1:0]    sel4, sel1;
  logic          vld4, vld1, last4, last1, busy4, busy1, done4, done1;
  logic [CW-1:0] beat4, beat1;
  logic [1:0]    dbg4, dbg1;

  int n_vec;
  int n_err;

  // Per-instance reference model: the currently presented item plus the remaining schedule.
  ent_t       exp_q0[$];
  ent_t       exp_q1[$];
  ent_t       cur[2];
  logic [1:0] last_sel[2];

  mux_seq_ctrl #(.LEN(4), .CW(CW)) u4 (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
`ifdef MUX_SEQ_LANE_MASK_EN
    .lane_mask(lane_mask),
`endif
    .sel(sel4), .sel_valid(vld4), .lane_last(last4), .busy(busy4),
    .done(done4), .beat(beat4), .dbg_state(dbg4)
  );

  mux_seq_ctrl #(.LEN(1), .CW(CW)) u1 (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
`ifdef MUX_SEQ_LANE_MASK_EN
    .lane_mask(lane_mask),
`endif
    .sel(sel1), .sel_valid(vld1), .lane_last(last1), .busy(busy1),
    .done(done1), .beat(beat1), .dbg_state(dbg1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] eff_mask();
`ifdef MUX_SEQ_LANE_MASK_EN
    return lane_mask;
`else
    return 4'hF;
`endif
  endfunction

  function automatic void q_push(input int k, input ent_t e);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic ent_t q_pop(input int k);
    if (k == 0) return exp_q0.pop_front();
    else        return exp_q1.pop_front();
  endfunction

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int k = 0; k < 2; k++) begin
      cur[k]      = {K_IDLE, 2'd0, 8'd0};
      last_sel[k] = 2'd0;
    end
  endtask

  // One active clock edge with ce=1: accept a start from idle by listing every beat to issue.
  task automatic model_edge(input int k, input int len);
    logic [3:0] m;
    if (cur[k][11:10] == K_IDLE) begin
      if (start) begin
        m = eff_mask();
        for (int l = 0; l < 4; l++)
          if (m[l])
            for (int b = 0; b < len; b++) q_push(k, {K_BEAT, 2'(l), 8'(b)});
        q_push(k, {K_DONE, 2'd0, 8'd0});
        cur[k] = q_pop(k);
      end
    end else if (q_size(k) == 0) begin
      cur[k] = {K_IDLE, 2'd0, 8'd0};
    end else begin
      cur[k] = q_pop(k);
    end
    if (cur[k][11:10] == K_BEAT) last_sel[k] = cur[k][9:8];
  endtask

  task automatic check_inst(input int k, input int len);
    logic [1:0] kind;
    int e_sel, e_beat;
    int a_sel, a_beat, a_vld, a_last, a_busy, a_done;
    string p;
    kind   = cur[k][11:10];
    e_sel  = (kind == K_BEAT) ? int'(cur[k][9:8]) : int'(last_sel[k]);
    e_beat = (kind == K_BEAT) ? int'(cur[k][7:0]) : 0;
    if (k == 0) begin
      a_sel = sel4; a_beat = beat4; a_vld = vld4; a_last = last4; a_busy = busy4; a_done = done4;
    end else begin
      a_sel = sel1; a_beat = beat1; a_vld = vld1; a_last = last1; a_busy = busy1; a_done = done1;
    end
    p = $sformatf("len%0d.", len);
    check_eq({p, "sel"},       a_sel,  e_sel);
    check_eq({p, "beat"},      a_beat, e_beat);
    check_eq({p, "sel_valid"}, a_vld,  int'(kind == K_BEAT));
    check_eq({p, "lane_last"}, a_last, int'((kind == K_BEAT) && (e_beat == len - 1)));
    check_eq({p, "busy"},      a_busy, int'(kind != K_IDLE));
    check_eq({p, "done"},      a_done, int'(kind == K_DONE));
  endtask

  task automatic check_all();
    check_inst(0, 4);
    check_inst(1, 1);
  endtask

  // Driver: inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic do_cycle(input logic ce_v, input logic start_v, input logic rst_v);
    @(negedge clk);
    ce        = ce_v;
    start     = start_v;
    lane_mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    rst       = rst_v;
    if (rst_v) begin
      #1;
      model_reset();
      check_all();
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (ce) begin
      model_edge(0, 4);
      model_edge(1, 1);
    end
    check_all();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    ce        = 1'b0;
    start     = 1'b0;
    lane_mask = 4'hF;
    model_reset();
    #2 rst = 1'b1;
    #1 check_all();
    repeat (2) do_cycle(1'b1, 1'b0, 1'b1);

    // Full-rate runs with sparse start pulses
    repeat (200) do_cycle(1'b1, ($urandom_range(0, 9) == 0), 1'b0);
    // start held high: back-to-back sequences with one idle cycle between
    repeat (60) do_cycle(1'b1, 1'b1, 1'b0);
    // Random clock-enable gating
    repeat (400) do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
    // Random gating plus occasional asynchronous resets mid-sequence
    repeat (600) do_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 39) == 0));
    // Strict ce=1 run after a reset to confirm a clean restart
    do_cycle(1'b1, 1'b0, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b0);
    repeat (20) do_cycle(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_seq_ctrl.md
MUX_SEQ_CTRL -- requirements
Module: mux_seq_ctrl

Interface
REQ-001 Parameter LEN, default 8: beats issued per lane; legal range 1..256.
REQ-002 Parameter CW, default 8: beat counter width; SHALL satisfy 2^CW >= LEN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ce  input  1  clock enable; when 0, all state and outputs hold.
REQ-006 start  input  1  request one sequence; sampled only in IDLE with ce=1.
REQ-007 sel  output  2  lane select driven to the downstream 4:1 mux (sel[1] MSB).
REQ-008 sel_valid  output  1  high while sel addresses a lane being issued.
REQ-009 lane_last  output  1  high on the final beat of the current lane.
REQ-010 busy  output  1  high in RUN and DONE states.
REQ-011 done  output  1  one-cycle pulse at the end of a sequence.
REQ-012 beat  output  CW  beat index within the current lane.

Function
REQ-013 States SHALL be IDLE, RUN and DONE; every transition SHALL require ce=1.
REQ-014 IDLE + start -> RUN next cycle, with sel = first enabled lane, beat=0, sel_valid=1.
REQ-015 In RUN each ce cycle: if beat<LEN-1 then beat+1, else beat->0 and sel -> next enabled lane.
REQ-016 lane_last SHALL equal (state==RUN && beat==LEN-1), combinationally from registers.
REQ-017 Final beat of the last enabled lane -> DONE; sel_valid=0, done=1 for exactly one ce cycle; then IDLE.
REQ-018 Outputs SHALL be registered; sel is stable for LEN consecutive ce=1 cycles per lane.
REQ-019 LEN=1: each lane lasts one beat, and lane_last=1 on every RUN cycle.
REQ-020 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-021 start asserted in the same cycle that done is high SHALL be ignored; a new start is accepted from IDLE on the following cycle.
REQ-022 ce=0 mid-lane SHALL freeze sel, beat, sel_valid and state; the sequence resumes on the next ce=1 cycle without losing a beat.
REQ-023 In IDLE, sel SHALL hold its last value, and sel_valid, lane_last and done SHALL be 0.

Reset
REQ-024 rst=1 SHALL force IDLE, sel=0, beat=0, sel_valid=0, busy=0, done=0, regardless of clk or ce.
REQ-025 rst asserted mid-sequence SHALL abort it, with no done pulse; after release the block SHALL wait for a new start.
REQ-026 First start accepted after rst deasserts SHALL behave identically to a start after a normal completion.

Configuration
REQ-027 Macro MUX_SEQ_LANE_MASK_EN defined: input lane_mask[3:0] is added; it is sampled on accepted start, and lanes whose bit is 0 are skipped.
REQ-028 With MUX_SEQ_LANE_MASK_EN, lane_mask=4'b0000 at start SHALL go IDLE -> DONE directly: done pulses once, sel_valid stays 0.
REQ-029 With MUX_SEQ_LANE_MASK_EN, lane_mask changes during RUN SHALL have no effect on the running sequence.
REQ-030 Macro undefined: no lane_mask port; all four lanes are issued in order 0,1,2,3.

Verification
REQ-031 LEN=4, ce=1, start pulse -> sel 0,0,0,0,1,1,1,1,2,...,3; lane_last on beats 3,7,11,15; done on cycle 17 after start.
REQ-032 LEN=4, ce toggling 1/0 every cycle -> same sel sequence at half rate; total 16 issued beats; one done pulse.
REQ-033 LEN=4, rst pulse at beat 6 (sel=1) -> sel=0, busy=0 immediately; no done; next start restarts at sel=0, beat=0.
REQ-034 start held high for 40 cycles, LEN=4 -> back-to-back sequences separated by one IDLE cycle after each done.
REQ-035 MUX_SEQ_LANE_MASK_EN, lane_mask=4'b1010, LEN=2 -> sel 1,1,3,3 then done; lane_mask=0 -> done one cycle after start.
REQ-036 LEN=1, no mask -> sel 0,1,2,3 on consecutive cycles, lane_last=1 on all four, done on the fifth cycle.
